// File: rtl/jk_reg_bank_pkg.sv
// Shared constants for the JK register bank: mode select and per-cell JK codes.
package jk_reg_pkg;
  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // {J,K} codes for one cell
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;
endpackage

// File: rtl/jk_reg_bank_if.sv
// Control/data bundle of the JK register bank; master drives en/mode/jk.
interface jk_reg_bank_if #(parameter int WIDTH = 4);
  logic               en;
  logic [1:0]         mode;
  logic [2*WIDTH-1:0] jk;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   qbar;
  logic               tc;

  modport master (output en, mode, jk, input q, qbar, tc);
  modport slave  (input en, mode, jk, output q, qbar, tc);
endinterface

// File: rtl/jk_reg_bank_cell.sv
// Single JK flip-flop with synchronous active-high clear and clock enable.
module jk_cell
  import jk_reg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK next-state: hold / clear / set / toggle
  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else if (en) begin
      case ({j, k})
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK cells with JK / up-count / down-count / load modes.
// Optional macro JK_REG_BANK_SAT_EN makes the counters saturate instead of wrap.
module jk_reg_bank
  import jk_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  jk_reg_bank_if.slave  bus
);

  logic [WIDTH-1:0] j_s, k_s, q_s;
  logic [WIDTH:0]   ones_pfx, zeros_pfx;
  logic             up_end, dn_end, tc_q;

  // prefix all-ones / all-zeros of q[i-1:0]; bit i of each is cell i's toggle condition
  always_comb begin
    ones_pfx     = '0;
    zeros_pfx    = '0;
    ones_pfx[0]  = 1'b1;
    zeros_pfx[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      ones_pfx[i+1]  = ones_pfx[i]  &  q_s[i];
      zeros_pfx[i+1] = zeros_pfx[i] & ~q_s[i];
    end
  end

  assign up_end = ones_pfx[WIDTH];
  assign dn_end = zeros_pfx[WIDTH];

  // per-cell J/K steering; count modes never look at jk so X there cannot reach q
  always_comb begin
    j_s = '0;
    k_s = '0;
    case (bus.mode)
      MODE_JK: begin
        for (int i = 0; i < WIDTH; i++) begin
          j_s[i] = bus.jk[2*i+1];
          k_s[i] = bus.jk[2*i];
        end
      end
      MODE_UP: begin
`ifdef JK_REG_BANK_SAT_EN
        j_s = up_end ? '0 : ones_pfx[WIDTH-1:0];
`else
        j_s = ones_pfx[WIDTH-1:0];
`endif
        k_s = j_s;
      end
      MODE_DOWN: begin
`ifdef JK_REG_BANK_SAT_EN
        j_s = dn_end ? '0 : zeros_pfx[WIDTH-1:0];
`else
        j_s = zeros_pfx[WIDTH-1:0];
`endif
        k_s = j_s;
      end
      default: begin
        for (int i = 0; i < WIDTH; i++) begin
          j_s[i] =  bus.jk[2*i+1];
          k_s[i] = ~bus.jk[2*i+1];
        end
      end
    endcase
  end

  // terminal count: one-cycle pulse on wrap (or every saturated cycle in the SAT build)
  always_ff @(posedge clk) begin
    if (rst)          tc_q <= 1'b0;
    else if (!bus.en) tc_q <= 1'b0;
    else              tc_q <= ((bus.mode == MODE_UP)   && up_end) ||
                              ((bus.mode == MODE_DOWN) && dn_end);
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (bus.en),
      .j   (j_s[g]),
      .k   (k_s[g]),
      .q   (q_s[g])
    );
  end

  assign bus.q    = q_s;
  assign bus.qbar = ~q_s;
  assign bus.tc   = tc_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank (WIDTH = 4): directed scenarios plus
// random traffic compared against an arithmetic reference model.
module tb_jk_reg_bank;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [W-1:0] mq;
  logic         mtc;

  jk_reg_bank_if #(.WIDTH(W)) bus ();

  jk_reg_bank #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // reference: next state from plain arithmetic on the register value
  task automatic model(input logic r, input logic e, input logic [1:0] m, input logic [2*W-1:0] j);
    if (r) begin
      mq = '0; mtc = 1'b0;
    end else if (!e) begin
      mtc = 1'b0;
    end else begin
      case (m)
        2'b00: begin
          mtc = 1'b0;
          for (int i = 0; i < W; i++) begin
            if (j[2*i+1] && j[2*i])  mq[i] = ~mq[i];
            else if (j[2*i+1])       mq[i] = 1'b1;
            else if (j[2*i])         mq[i] = 1'b0;
          end
        end
        2'b01: begin
          mtc = (mq == 4'd15);
`ifdef JK_REG_BANK_SAT_EN
          if (mq != 4'd15) mq = mq + 4'd1;
`else
          mq = mq + 4'd1;
`endif
        end
        2'b10: begin
          mtc = (mq == 4'd0);
`ifdef JK_REG_BANK_SAT_EN
          if (mq != 4'd0) mq = mq - 4'd1;
`else
          mq = mq - 4'd1;
`endif
        end
        default: begin
          mtc = 1'b0;
          for (int i = 0; i < W; i++) mq[i] = j[2*i+1];
        end
      endcase
    end
  endtask

  // one clock: drive on negedge, sample 1 time unit after posedge, compare with model
  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [2*W-1:0] j);
    @(negedge clk);
    rst = r; bus.en = e; bus.mode = m; bus.jk = j;
    @(posedge clk);
    model(r, e, m, j);
    #1;
    chk("model_q",    bus.q,    mq);
    chk("model_qbar", bus.qbar, ~mq);
    chk("model_tc",   {3'b000, bus.tc}, {3'b000, mtc});
  endtask

  initial begin
    logic [2*W-1:0] xjk;
    mq = '0; mtc = 1'b0;
    rst = 1'b1; bus.en = 1'b1; bus.mode = 2'b01; bus.jk = '0;

    // 1. reset, then count up three times
    step(1, 1, 2'b01, '0);
    step(1, 1, 2'b01, '0);
    chk("rst_q", bus.q, 4'b0000);
    chk("rst_qbar", bus.qbar, 4'b1111);
    chk("rst_tc", {3'b000, bus.tc}, 4'b0000);
    repeat (3) step(0, 1, 2'b01, '0);
    chk("up3_q", bus.q, 4'b0011);

    // 2. JK mode; pairs written cell 3 first
    step(1, 1, 2'b00, '0);
    step(0, 1, 2'b00, 8'b10_10_10_10);
    chk("jk_set_q", bus.q, 4'b1111);
    step(0, 1, 2'b00, 8'b11_00_01_11);   // tgl, hold, clr, tgl
    chk("jk_mix_q", bus.q, 4'b0100);
    step(0, 1, 2'b00, 8'b00_00_00_00);
    chk("jk_hold_q", bus.q, 4'b0100);

`ifndef JK_REG_BANK_SAT_EN
    // 3. up wrap
    step(0, 1, 2'b11, 8'b10_10_10_01);   // K ignored in LOAD
    chk("load_q", bus.q, 4'b1110);
    step(0, 1, 2'b01, '0);
    chk("upw1_q", bus.q, 4'b1111);
    chk("upw1_tc", {3'b000, bus.tc}, 4'b0000);
    step(0, 1, 2'b01, '0);
    chk("upw2_q", bus.q, 4'b0000);
    chk("upw2_tc", {3'b000, bus.tc}, 4'b0001);
    step(0, 1, 2'b01, '0);
    chk("upw3_q", bus.q, 4'b0001);
    chk("upw3_tc", {3'b000, bus.tc}, 4'b0000);

    // 4. down wrap then enable low
    step(0, 1, 2'b10, '0);
    chk("dn1_q", bus.q, 4'b0000);
    step(0, 1, 2'b10, '0);
    chk("dn2_q", bus.q, 4'b1111);
    chk("dn2_tc", {3'b000, bus.tc}, 4'b0001);
    repeat (3) begin
      step(0, 0, 2'b10, '0);
      chk("en0_q", bus.q, 4'b1111);
      chk("en0_tc", {3'b000, bus.tc}, 4'b0000);
    end
`else
    // 6. saturating build
    step(0, 1, 2'b11, 8'b10_10_10_00);
    step(0, 1, 2'b01, '0);
    chk("sat1_q", bus.q, 4'b1111);
    chk("sat1_tc", {3'b000, bus.tc}, 4'b0000);
    step(0, 1, 2'b01, '0);
    chk("sat2_q", bus.q, 4'b1111);
    chk("sat2_tc", {3'b000, bus.tc}, 4'b0001);
    step(0, 1, 2'b01, '0);
    chk("sat3_q", bus.q, 4'b1111);
    chk("sat3_tc", {3'b000, bus.tc}, 4'b0001);
    step(0, 1, 2'b10, '0);
    chk("satdn_q", bus.q, 4'b1110);
    chk("satdn_tc", {3'b000, bus.tc}, 4'b0000);
`endif

    // 5. reset mid-count
    step(0, 1, 2'b11, 8'b00_10_00_10);
    step(0, 1, 2'b01, '0);
    chk("mid1_q", bus.q, 4'b0110);
    step(0, 1, 2'b01, '0);
    chk("mid2_q", bus.q, 4'b0111);
    step(1, 1, 2'b01, '0);
    chk("mid3_q", bus.q, 4'b0000);
    chk("mid3_tc", {3'b000, bus.tc}, 4'b0000);

    // full up cycle: one tc pulse per 16 edges
    begin
      int pulses = 0;
      for (int i = 0; i < 32; i++) begin
        step(0, 1, 2'b01, '0);
        if (bus.tc) pulses++;
      end
`ifndef JK_REG_BANK_SAT_EN
      chk("up_pulses", pulses[W-1:0], 4'd2);
`endif
    end

    // X on jk in count modes must not disturb q
    xjk = 'x;
    step(0, 1, 2'b10, xjk);
    step(0, 1, 2'b01, xjk);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic r;
      r = ($urandom_range(0, 39) == 0);
      step(r, ($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
